// File: rtl/eth_tx_sched_pkg.sv
// Shared constants and FSM encoding for the Ethernet TX scheduler.
// Frame types mirror the eth_tx_type / eth_rx_type field values.
package eth_tx_sched_pkg;

    localparam logic [1:0] ETH_TYPE_ARP  = 2'd1;
    localparam logic [1:0] ETH_TYPE_ICMP = 2'd2;
    localparam logic [1:0] ETH_TYPE_UDP  = 2'd3;

    localparam logic ARP_OP_REQ   = 1'b0;
    localparam logic ARP_OP_REPLY = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_BUSY      = 2'd3
    } state_e;

endpackage

// File: rtl/eth_tx_sched_rr_arb.sv
// Round-robin picker: lowest requesting index at or above ptr,
// otherwise wraps to the lowest requesting index overall.
module rr_arb #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_vld,
    output logic [CH_W-1:0] gnt_idx
);

    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) gnt_idx = CH_W'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i] && (CH_W'(i) >= ptr)) gnt_idx = CH_W'(i);
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Ethernet TX scheduler: queues ARP/ICMP/UDP send requests, grants one
// frame at a time to the transmitter and steers its payload bytes.
module eth_tx_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arp_req,
    input  logic              rx_done,
    input  logic [1:0]        eth_rx_type,
    input  logic              arp_rx_type,
    input  logic              icmp_echo,
    input  logic [15:0]       icmp_rx_len,
    input  logic              tx_rdy,
    output logic              eth_tx_start,
    output logic [1:0]        eth_tx_type,
    output logic              arp_tx_type,
    output logic [15:0]       tx_byte_num,
    output logic [CH_W-1:0]   tx_ch,
    input  logic              tx_data_req,
    output logic [7:0]        tx_data,
    input  logic [NCH-1:0]    udp_tx_en,
    input  logic [NCH*16-1:0] udp_tx_num,
    input  logic [NCH*8-1:0]  udp_tx_data,
    output logic [NCH-1:0]    udp_tx_req,
    output logic [NCH-1:0]    udp_tx_done,
    output logic              icmp_rd_en,
    input  logic [7:0]        icmp_rdata
);

    state_e state_q, state_d;

    logic                  arp_pend_q, arp_pend_d;
    logic                  arp_op_q, arp_op_d;
    logic                  icmp_pend_q, icmp_pend_d;
    logic [15:0]           icmp_len_q, icmp_len_d;
    logic [NCH-1:0]        udp_pend_q, udp_pend_d;
    logic [NCH-1:0][15:0]  udp_len_q, udp_len_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [1:0]            type_q, type_d;
    logic                  arp_tx_q, arp_tx_d;
    logic [15:0]           byte_num_q, byte_num_d;
    logic [CH_W-1:0]       ch_q, ch_d;

    logic [NCH-1:0]        done_q, done_d;
    logic                  icmp_rd_q, icmp_rd_d;
    logic [NCH-1:0]        udp_req_q, udp_req_d;
    logic [7:0]            data_q, data_d;

    logic [NCH-1:0][15:0]  udp_num;
    logic [NCH-1:0][7:0]   udp_byte;
    logic                  rr_vld;
    logic [CH_W-1:0]       rr_idx;

    logic arp_rx_trig, arp_trig, icmp_trig;
    logic grant, gnt_arp, gnt_icmp, gnt_udp;
    logic data_phase;
    logic [NCH-1:0] udp_gnt_oh;

    assign udp_num  = udp_tx_num;
    assign udp_byte = udp_tx_data;

    rr_arb #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_rr_arb (
        .req     (udp_pend_q),
        .ptr     (rr_ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        arp_rx_trig = rx_done && (eth_rx_type == ETH_TYPE_ARP)
                      && (arp_rx_type == ARP_OP_REQ);
        arp_trig    = arp_req || arp_rx_trig;
        icmp_trig   = rx_done && (eth_rx_type == ETH_TYPE_ICMP) && icmp_echo;

        grant    = (state_q == S_IDLE) && tx_rdy
                   && (arp_pend_q || icmp_pend_q || rr_vld);
        gnt_arp  = grant && arp_pend_q;
        gnt_icmp = grant && !arp_pend_q && icmp_pend_q;
        gnt_udp  = grant && !arp_pend_q && !icmp_pend_q && rr_vld;

        udp_gnt_oh = '0;
        udp_gnt_oh[rr_idx] = gnt_udp;

        // A trigger in its own grant cycle re-arms the flag.
        arp_pend_d  = (arp_pend_q && !gnt_arp) || arp_trig;
        icmp_pend_d = (icmp_pend_q && !gnt_icmp) || icmp_trig;
        udp_pend_d  = (udp_pend_q & ~udp_gnt_oh) | udp_tx_en;

        arp_op_d = arp_op_q;
        if (arp_req) arp_op_d = ARP_OP_REQ;
        else if (arp_rx_trig) arp_op_d = ARP_OP_REPLY;

        icmp_len_d = icmp_trig ? icmp_rx_len : icmp_len_q;
        for (int i = 0; i < NCH; i++) begin
            udp_len_d[i] = udp_tx_en[i] ? udp_num[i] : udp_len_q[i];
        end

        type_d     = type_q;
        arp_tx_d   = arp_tx_q;
        byte_num_d = byte_num_q;
        ch_d       = ch_q;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_arp) begin
            type_d     = ETH_TYPE_ARP;
            arp_tx_d   = arp_op_q;
            byte_num_d = '0;
            ch_d       = '0;
        end else if (gnt_icmp) begin
            type_d     = ETH_TYPE_ICMP;
            arp_tx_d   = 1'b0;
            byte_num_d = icmp_len_q;
            ch_d       = '0;
        end else if (gnt_udp) begin
            type_d     = ETH_TYPE_UDP;
            arp_tx_d   = 1'b0;
            byte_num_d = udp_len_q[rr_idx];
            ch_d       = rr_idx;
            rr_ptr_d   = (rr_idx == CH_W'(NCH - 1)) ? '0 : rr_idx + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (grant) state_d = S_START;
            S_START:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!tx_rdy) state_d = S_BUSY;
            S_BUSY:      if (tx_rdy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        done_d = '0;
        if ((state_q == S_BUSY) && tx_rdy && (type_q == ETH_TYPE_UDP)) begin
            done_d[ch_q] = 1'b1;
        end

        data_phase = (state_q == S_WAIT_BUSY) || (state_q == S_BUSY);
        icmp_rd_d  = tx_data_req && data_phase && (type_q == ETH_TYPE_ICMP);
        udp_req_d  = '0;
        udp_req_d[ch_q] = tx_data_req && data_phase
                          && (type_q == ETH_TYPE_UDP);

        data_d = 8'h00;
        if (type_q == ETH_TYPE_ICMP) data_d = icmp_rdata;
        else if (type_q == ETH_TYPE_UDP) data_d = udp_byte[ch_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            arp_pend_q  <= 1'b0;
            arp_op_q    <= 1'b0;
            icmp_pend_q <= 1'b0;
            icmp_len_q  <= '0;
            udp_pend_q  <= '0;
            udp_len_q   <= '0;
            rr_ptr_q    <= '0;
            type_q      <= '0;
            arp_tx_q    <= 1'b0;
            byte_num_q  <= '0;
            ch_q        <= '0;
            done_q      <= '0;
            icmp_rd_q   <= 1'b0;
            udp_req_q   <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            arp_pend_q  <= arp_pend_d;
            arp_op_q    <= arp_op_d;
            icmp_pend_q <= icmp_pend_d;
            icmp_len_q  <= icmp_len_d;
            udp_pend_q  <= udp_pend_d;
            udp_len_q   <= udp_len_d;
            rr_ptr_q    <= rr_ptr_d;
            type_q      <= type_d;
            arp_tx_q    <= arp_tx_d;
            byte_num_q  <= byte_num_d;
            ch_q        <= ch_d;
            done_q      <= done_d;
            icmp_rd_q   <= icmp_rd_d;
            udp_req_q   <= udp_req_d;
            data_q      <= data_d;
        end
    end

    assign eth_tx_start = (state_q == S_START);
    assign eth_tx_type  = type_q;
    assign arp_tx_type  = arp_tx_q;
    assign tx_byte_num  = byte_num_q;
    assign tx_ch        = ch_q;
    assign udp_tx_done  = done_q;
    assign icmp_rd_en   = icmp_rd_q;
    assign udp_tx_req   = udp_req_q;
    assign tx_data      = data_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: priority, round-robin, payload
// steering, re-trigger, reset-in-frame and tx_rdy gating.
module tb_eth_tx_sched;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arp_req;
    logic              rx_done;
    logic [1:0]        eth_rx_type;
    logic              arp_rx_type;
    logic              icmp_echo;
    logic [15:0]       icmp_rx_len;
    logic              tx_rdy;
    logic              eth_tx_start;
    logic [1:0]        eth_tx_type;
    logic              arp_tx_type;
    logic [15:0]       tx_byte_num;
    logic [CH_W-1:0]   tx_ch;
    logic              tx_data_req;
    logic [7:0]        tx_data;
    logic [NCH-1:0]    udp_tx_en;
    logic [NCH*16-1:0] udp_tx_num;
    logic [NCH*8-1:0]  udp_tx_data;
    logic [NCH-1:0]    udp_tx_req;
    logic [NCH-1:0]    udp_tx_done;
    logic              icmp_rd_en;
    logic [7:0]        icmp_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_addr = 8'h00;
    int done_cnt [NCH];

    always #5 clk = ~clk;

    // ICMP echo buffer: byte at address a is 0xA5 ^ a, one cycle latency.
    always @(posedge clk) begin
        if (icmp_rd_en) begin
            icmp_rdata <= 8'hA5 ^ rd_addr;
            rd_addr    <= rd_addr + 8'd1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (udp_tx_done[i]) done_cnt[i]++;
        end
    end

    eth_tx_sched #(.NCH(NCH), .CH_W(CH_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arp_req      (arp_req),
        .rx_done      (rx_done),
        .eth_rx_type  (eth_rx_type),
        .arp_rx_type  (arp_rx_type),
        .icmp_echo    (icmp_echo),
        .icmp_rx_len  (icmp_rx_len),
        .tx_rdy       (tx_rdy),
        .eth_tx_start (eth_tx_start),
        .eth_tx_type  (eth_tx_type),
        .arp_tx_type  (arp_tx_type),
        .tx_byte_num  (tx_byte_num),
        .tx_ch        (tx_ch),
        .tx_data_req  (tx_data_req),
        .tx_data      (tx_data),
        .udp_tx_en    (udp_tx_en),
        .udp_tx_num   (udp_tx_num),
        .udp_tx_data  (udp_tx_data),
        .udp_tx_req   (udp_tx_req),
        .udp_tx_done  (udp_tx_done),
        .icmp_rd_en   (icmp_rd_en),
        .icmp_rdata   (icmp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!eth_tx_start && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_start"}, 64'(eth_tx_start), 64'd1);
    endtask

    task automatic no_start(input string tag, input int ncyc);
        int c = 0;
        repeat (ncyc) begin
            step();
            if (eth_tx_start) c++;
        end
        chk(tag, 64'(c), 64'd0);
    endtask

    // Start, walk the transmitter through busy, pull one payload byte, end.
    task automatic frame(input string tag, input logic [1:0] et,
                         input logic at, input logic [15:0] num,
                         input logic [CH_W-1:0] ch);
        logic [NCH-1:0] oh;
        oh = '0;
        if (et == 2'd3) oh[ch] = 1'b1;
        wait_start(tag);
        chk({tag, "_type"}, 64'(eth_tx_type), 64'(et));
        chk({tag, "_arp"}, 64'(arp_tx_type), 64'(at));
        chk({tag, "_num"}, 64'(tx_byte_num), 64'(num));
        chk({tag, "_ch"}, 64'(tx_ch), 64'(ch));
        tx_rdy = 1'b0;
        step();
        step();
        tx_data_req = 1'b1;
        step();
        tx_data_req = 1'b0;
        chk({tag, "_rd"}, 64'(icmp_rd_en), 64'(et == 2'd2));
        chk({tag, "_ureq"}, 64'(udp_tx_req), 64'(oh));
        step();
        step();
        if (et == 2'd3) chk({tag, "_data"}, 64'(tx_data), 64'(udp_tx_data[ch*8 +: 8]));
        tx_rdy = 1'b1;
        step();
        chk({tag, "_done"}, 64'(udp_tx_done), 64'(oh));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] base;
        logic [7:0] exp_b;
        int rd_cnt;
        int d2;
        int d3;

        rst_n       = 1'b0;
        arp_req     = 1'b0;
        rx_done     = 1'b0;
        eth_rx_type = 2'd0;
        arp_rx_type = 1'b0;
        icmp_echo   = 1'b0;
        icmp_rx_len = 16'd0;
        tx_rdy      = 1'b1;
        tx_data_req = 1'b0;
        udp_tx_en   = '0;
        udp_tx_num  = '0;
        udp_tx_data = {8'h44, 8'h33, 8'h22, 8'h11};

        repeat (3) step();
        chk("rst_ctl", 64'({eth_tx_start, eth_tx_type, arp_tx_type, tx_byte_num, tx_ch}), 64'd0);
        chk("rst_dat", 64'({tx_data, udp_tx_req, udp_tx_done, icmp_rd_en}), 64'd0);
        rst_n = 1'b1;
        no_start("idle_nostart", 3);

        // Two UDP channels together: round-robin from pointer 0.
        udp_tx_num[1*16 +: 16] = 16'd64;
        udp_tx_num[3*16 +: 16] = 16'd300;
        udp_tx_en = 4'b1010;
        step();
        udp_tx_en = '0;
        frame("u1", 2'd3, 1'b0, 16'd64, 2'd1);
        frame("u3", 2'd3, 1'b0, 16'd300, 2'd3);

        // Everything pending while transmitter is busy; then priority order.
        tx_rdy = 1'b0;
        arp_req = 1'b1;
        udp_tx_num[0 +: 16] = 16'd18;
        udp_tx_en = 4'b0001;
        step();
        arp_req = 1'b0;
        udp_tx_en = '0;
        rx_done = 1'b1;
        eth_rx_type = 2'd2;
        icmp_echo = 1'b1;
        icmp_rx_len = 16'd10;
        step();
        rx_done = 1'b0;
        icmp_echo = 1'b0;
        no_start("rdy_low_nostart", 10);
        tx_rdy = 1'b1;
        frame("arp", 2'd1, 1'b0, 16'd0, 2'd0);
        frame("icmp", 2'd2, 1'b0, 16'd10, 2'd0);
        frame("u0", 2'd3, 1'b0, 16'd18, 2'd0);

        // Received ARP reply and non-echo ICMP must not trigger.
        rx_done = 1'b1;
        eth_rx_type = 2'd1;
        arp_rx_type = 1'b1;
        step();
        eth_rx_type = 2'd2;
        icmp_echo = 1'b0;
        step();
        rx_done = 1'b0;
        no_start("rx_nontrig", 5);

        // Received ARP request -> reply-mode ARP.
        rx_done = 1'b1;
        eth_rx_type = 2'd1;
        arp_rx_type = 1'b0;
        step();
        rx_done = 1'b0;
        frame("arp_rep", 2'd1, 1'b1, 16'd0, 2'd0);

        // 32-byte ICMP echo payload, 2-cycle data lag.
        rx_done = 1'b1;
        eth_rx_type = 2'd2;
        icmp_echo = 1'b1;
        icmp_rx_len = 16'd32;
        step();
        rx_done = 1'b0;
        icmp_echo = 1'b0;
        wait_start("icmp32");
        chk("icmp32_type", 64'(eth_tx_type), 64'd2);
        chk("icmp32_num", 64'(tx_byte_num), 64'd32);
        tx_rdy = 1'b0;
        step();
        step();
        base = rd_addr;
        rd_cnt = 0;
        tx_data_req = 1'b1;
        for (int k = 0; k < 34; k++) begin
            step();
            if (k == 31) tx_data_req = 1'b0;
            if (icmp_rd_en) rd_cnt++;
            if (k >= 2) begin
                exp_b = 8'hA5 ^ (base + 8'(k - 2));
                chk($sformatf("icmp32_b%0d", k - 2), 64'(tx_data), 64'(exp_b));
            end
        end
        chk("icmp32_rdcnt", 64'(rd_cnt), 64'd32);
        tx_rdy = 1'b1;
        step();
        chk("icmp32_done", 64'(udp_tx_done), 64'd0);
        tx_data_req = 1'b1;
        step();
        tx_data_req = 1'b0;
        chk("idle_req_ign", 64'(icmp_rd_en), 64'd0);
        step();

        // Re-trigger channel 2 exactly in its grant cycle.
        d2 = done_cnt[2];
        udp_tx_num[2*16 +: 16] = 16'd100;
        udp_tx_en = 4'b0100;
        step();
        udp_tx_num[2*16 +: 16] = 16'd200;
        step();
        udp_tx_en = '0;
        frame("u2a", 2'd3, 1'b0, 16'd100, 2'd2);
        frame("u2b", 2'd3, 1'b0, 16'd200, 2'd2);
        step();
        chk("u2_done_cnt", 64'(done_cnt[2] - d2), 64'd2);
        no_start("u2_no_third", 5);

        // Reset in the middle of a UDP frame.
        udp_tx_num[3*16 +: 16] = 16'd77;
        udp_tx_en = 4'b1000;
        step();
        udp_tx_en = '0;
        wait_start("u3r");
        chk("u3r_ch", 64'(tx_ch), 64'd3);
        tx_rdy = 1'b0;
        step();
        step();
        tx_data_req = 1'b1;
        udp_tx_en = 4'b0001;
        step();
        tx_data_req = 1'b0;
        udp_tx_en = '0;
        chk("u3r_ureq", 64'(udp_tx_req), 64'b1000);
        d3 = done_cnt[3];
        rst_n = 1'b0;
        tx_rdy = 1'b1;
        step();
        chk("midrst_ctl", 64'({eth_tx_start, eth_tx_type, arp_tx_type, tx_byte_num, tx_ch}), 64'd0);
        chk("midrst_dat", 64'({tx_data, udp_tx_req, udp_tx_done, icmp_rd_en}), 64'd0);
        step();
        rst_n = 1'b1;
        no_start("midrst_nostart", 6);
        chk("midrst_nodone", 64'(done_cnt[3] - d3), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 NCH, default 4: number of UDP user channels, legal range 1..8.
REQ-002 CH_W, default 2: channel index width, equal to max(1, ceil(log2(NCH))).
REQ-003 clk  in  1  system clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 arp_req  in  1  one-cycle pulse: send an ARP request.
REQ-006 rx_done  in  1  one-cycle pulse: receive frame complete.
REQ-007 eth_rx_type  in  2  received type: 1 ARP, 2 ICMP, 3 UDP.
REQ-008 arp_rx_type  in  1  received ARP opcode: 0 request, 1 reply.
REQ-009 icmp_echo  in  1  received ICMP is an echo request; valid with rx_done.
REQ-010 icmp_rx_len  in  16  received ICMP payload bytes; valid with rx_done.
REQ-011 tx_rdy  in  1  transmitter idle when high.
REQ-012 eth_tx_start  out  1  one-cycle start pulse.
REQ-013 eth_tx_type  out  2  frame type for the start: 1 ARP, 2 ICMP, 3 UDP.
REQ-014 arp_tx_type  out  1  0 ARP request, 1 ARP reply.
REQ-015 tx_byte_num  out  16  payload length of the started frame.
REQ-016 tx_ch  out  CH_W  granted UDP channel index.
REQ-017 tx_data_req  in  1  transmitter payload byte request.
REQ-018 tx_data  out  8  payload byte to transmitter.
REQ-019 udp_tx_en  in  NCH  per-channel one-cycle send request.
REQ-020 udp_tx_num  in  NCH*16  per-channel length; sampled with udp_tx_en.
REQ-021 udp_tx_data  in  NCH*8  per-channel payload byte.
REQ-022 udp_tx_req  out  NCH  per-channel byte request, one-hot or zero.
REQ-023 udp_tx_done  out  NCH  per-channel one-cycle frame-sent pulse.
REQ-024 icmp_rd_en  out  1  ICMP echo buffer read enable.
REQ-025 icmp_rdata  in  8  ICMP echo buffer data; valid one cycle after icmp_rd_en.

Function
REQ-026 Pending flags SHALL exist for ARP, ICMP and each UDP channel; each is set the cycle after its trigger and cleared the cycle after its grant.
REQ-027 ARP trigger SHALL be arp_req, or rx_done with eth_rx_type=1 and arp_rx_type=0; arp_req sets request-mode, the rx_done condition sets reply-mode, and arp_req wins if both occur together.
REQ-028 ICMP trigger SHALL be rx_done with eth_rx_type=2 and icmp_echo=1; icmp_rx_len is latched at the trigger.
REQ-029 UDP trigger SHALL be udp_tx_en[i]; udp_tx_num[i] is latched per channel at the trigger.
REQ-030 A trigger arriving in the same cycle as its own grant SHALL leave the flag set, so no request is lost.
REQ-031 FSM states SHALL be IDLE, START, WAIT_BUSY and BUSY.
REQ-032 IDLE->START SHALL occur when any flag is set and tx_rdy=1.
REQ-033 START SHALL assert eth_tx_start for exactly one cycle and then go to WAIT_BUSY.
REQ-034 WAIT_BUSY->BUSY SHALL occur on tx_rdy=0; BUSY->IDLE SHALL occur on tx_rdy=1.
REQ-035 Grant priority SHALL be ARP, then ICMP, then UDP.
REQ-036 UDP grants SHALL be round-robin, starting from the channel after the last UDP grant; the pointer is 0 after reset.
REQ-037 eth_tx_type, arp_tx_type, tx_byte_num and tx_ch SHALL be registered at grant and held until the next grant.
REQ-038 tx_byte_num SHALL be 0 for ARP.
REQ-039 udp_tx_done[tx_ch] SHALL pulse on BUSY->IDLE for a UDP frame only.
REQ-040 tx_data_req SHALL produce a registered icmp_rd_en (ICMP) or udp_tx_req[tx_ch] (UDP) one cycle later, and nothing for ARP.
REQ-041 tx_data SHALL be registered from icmp_rdata or udp_tx_data[tx_ch] and valid exactly 2 cycles after tx_data_req.
REQ-042 tx_data_req outside BUSY/WAIT_BUSY SHALL be ignored.

Reset
REQ-043 rst_n=0 SHALL clear all flags, the FSM (to IDLE), the round-robin pointer and latched lengths, and drive every output to 0, including mid-frame.

Structure
REQ-044 The shared package SHALL hold the frame-type constants (ARP=1, ICMP=2, UDP=3), the ARP opcode constants and the FSM state encoding.
REQ-045 The round-robin arbiter SHALL be a separate sub-module, rr_arb, parameterised by NCH.

Verification
REQ-046 With NCH=4, pulse udp_tx_en[1] and udp_tx_en[3] in the same cycle with tx_rdy=1 -> channel 1 starts first, then channel 3, each with its latched tx_byte_num.
REQ-047 With arp_req, an ICMP echo and udp_tx_en[0] pending together -> starts occur in the order ARP(type 1, arp_tx_type=0), ICMP(type 2), UDP(type 3, tx_ch=0).
REQ-048 With an ICMP len of 32 bytes, hold tx_data_req for 32 cycles -> 32 icmp_rd_en pulses, with tx_data equal to the buffer bytes at a lag of 2 cycles.
REQ-049 Re-pulse udp_tx_en[2] in the exact grant cycle -> channel 2 is sent twice, and udp_tx_done[2] pulses twice.
REQ-050 Assert rst_n=0 while in BUSY -> all outputs are 0 on the next cycle, and no udp_tx_done pulse occurs.
REQ-051 Hold tx_rdy=0 with flags set -> no eth_tx_start is issued until tx_rdy=1.
